// File: rtl/bus_slave_responder_if.sv
// bus_slave_responder_if: command/data bus between a master and one slave responder
interface bus_slave_responder_if #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
);
  logic [1:0]           instruction;
  logic [SLAVE_LEN-1:0] slave_select;
  logic [ADDR_LEN-1:0]  address;
  logic [BURST_LEN-1:0] burst_num;
  logic [DATA_LEN-1:0]  wr_data;
  logic                 wr_valid;
  logic                 rd_ready;
  logic [DATA_LEN-1:0]  rd_data;
  logic                 rd_valid;
  logic                 busy;
  logic                 tx_done;
  logic                 rx_done;
  logic                 err;
  modport master (
    output instruction, slave_select, address, burst_num, wr_data, wr_valid, rd_ready,
    input  rd_data, rd_valid, busy, tx_done, rx_done, err
  );
  modport slave (
    input  instruction, slave_select, address, burst_num, wr_data, wr_valid, rd_ready,
    output rd_data, rd_valid, busy, tx_done, rx_done, err
  );
endinterface

// File: rtl/bus_slave_responder.sv
// bus_slave_responder: slave end of the system bus, burst read/write into a small local memory
module bus_slave_responder #(
  parameter int SLAVE_LEN    = 2,
  parameter int ADDR_LEN     = 12,
  parameter int DATA_LEN     = 8,
  parameter int BURST_LEN    = 12,
  parameter int MEM_ADDR_LEN = 4,
  parameter int SLAVE_ID     = 0
) (
  input logic                 clk,
  input logic                 reset,
  bus_slave_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_n;
  logic [DATA_LEN-1:0] mem [2**MEM_ADDR_LEN];
  logic [MEM_ADDR_LEN-1:0] ptr, nxt;
  logic [BURST_LEN-1:0] remaining;
  logic [DATA_LEN-1:0] rd_data;
  logic rd_valid, busy, tx_done, rx_done, err;
  logic cmd, accept, oor, last, start, wr_fire, rd_fire;
  assign nxt = ptr + 1'b1;
  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.busy     = busy;
  assign bus.tx_done  = tx_done;
  assign bus.rx_done  = rx_done;
  assign bus.err      = err;
  // Dropping instruction[1] mid-transfer aborts; it takes priority over a beat in the same cycle
  always_comb begin
    cmd = bus.instruction[1];
    accept = cmd && bus.slave_select == SLAVE_LEN'(SLAVE_ID);
    oor = |bus.address[ADDR_LEN-1:MEM_ADDR_LEN];
    last = remaining == BURST_LEN'(1);
    start = state == IDLE && accept && !oor;
    wr_fire = state == WRITE && cmd && bus.wr_valid;
    rd_fire = state == READ && cmd && rd_valid && bus.rd_ready;
    state_n = state;
    case (state)
      IDLE:    state_n = !accept ? IDLE : oor ? DONE : bus.instruction[0] ? READ : WRITE;
      WRITE:   state_n = !cmd ? IDLE : (wr_fire && last) ? DONE : WRITE;
      READ:    state_n = !cmd ? IDLE : (rd_fire && last) ? DONE : READ;
      default: state_n = cmd ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      rx_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= state_n == WRITE || state_n == READ;
      rd_valid <= state_n == READ;
      tx_done  <= state == WRITE && state_n == DONE;
      rx_done  <= state == READ && state_n == DONE;
      err      <= state == IDLE && state_n == DONE;
      if (start) begin
        ptr       <= bus.address[MEM_ADDR_LEN-1:0];
        remaining <= bus.burst_num == '0 ? BURST_LEN'(1) : bus.burst_num;
        if (bus.instruction[0]) rd_data <= mem[bus.address[MEM_ADDR_LEN-1:0]];
      end else if (wr_fire || rd_fire) begin
        ptr       <= nxt;
        remaining <= remaining - 1'b1;
        if (rd_fire && !last) rd_data <= mem[nxt];
      end
    end
  // Memory has no reset so completed writes survive a reset
  always_ff @(posedge clk)
    if (wr_fire) mem[ptr] <= bus.wr_data;
endmodule

// File: tb/tb_bus_slave_responder.sv
// tb_bus_slave_responder: table-driven single-beat vectors plus directed burst/stall/abort/reset sequences
module tb_bus_slave_responder;
  logic clk, reset;
  int tests, fails;
  bus_slave_responder_if bus ();
  bus_slave_responder dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic [1:0] sel;
    logic [11:0] addr;
    logic [11:0] burst;
    logic [7:0] d;
    int         e_err, e_tx, e_rx, e_busy;
    logic [7:0] e_rdat;
  } vec_t;
  vec_t vt[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.instruction = 2'b00;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
  endtask

  task automatic txn(input logic rd, input logic [1:0] sel, input logic [11:0] addr,
                     input logic [11:0] burst, input logic [7:0] d,
                     output int n_err, output int n_tx, output int n_rx, output int n_busy,
                     output logic [7:0] rdat);
    n_err = 0; n_tx = 0; n_rx = 0; n_busy = 0; rdat = '0;
    bus.instruction = {1'b1, rd};
    bus.slave_select = sel;
    bus.address = addr;
    bus.burst_num = burst;
    bus.wr_data = d;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_err += int'(bus.err);
      n_tx += int'(bus.tx_done);
      n_rx += int'(bus.rx_done);
      n_busy += int'(bus.busy);
      if (bus.rd_valid) rdat = bus.rd_data;
      bus.wr_valid = bus.busy && !rd;
      bus.rd_ready = bus.rd_valid;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    int n_err, n_tx, n_rx, n_busy, hs;
    logic [7:0] rdat;
    logic [7:0] wdat [4];
    logic [7:0] bp_data [5];
    logic bp_ready [5];
    logic bp_valid [5];
    logic bp_rx [5];
    tests = 0;
    fails = 0;
    vt[0]  = '{1'b0, 2'd0, 12'h003, 12'd1, 8'hA5, 0, 1, 0, 1, 8'h00};
    vt[1]  = '{1'b1, 2'd0, 12'h003, 12'd1, 8'h00, 0, 0, 1, 1, 8'hA5};
    vt[2]  = '{1'b0, 2'd0, 12'h000, 12'd1, 8'h5A, 0, 1, 0, 1, 8'h00};
    vt[3]  = '{1'b0, 2'd2, 12'h000, 12'd1, 8'h77, 0, 0, 0, 0, 8'h00};
    vt[4]  = '{1'b0, 2'd0, 12'h010, 12'd1, 8'hEE, 1, 0, 0, 0, 8'h00};
    vt[5]  = '{1'b1, 2'd0, 12'h000, 12'd1, 8'h00, 0, 0, 1, 1, 8'h5A};
    vt[6]  = '{1'b0, 2'd0, 12'h007, 12'd0, 8'h3C, 0, 1, 0, 1, 8'h00};
    vt[7]  = '{1'b1, 2'd0, 12'h007, 12'd1, 8'h00, 0, 0, 1, 1, 8'h3C};
    vt[8]  = '{1'b1, 2'd0, 12'h800, 12'd1, 8'h00, 1, 0, 0, 0, 8'h00};
    vt[9]  = '{1'b1, 2'd1, 12'h003, 12'd1, 8'h00, 0, 0, 0, 0, 8'h00};
    vt[10] = '{1'b0, 2'd3, 12'h007, 12'd1, 8'h99, 0, 0, 0, 0, 8'h00};
    vt[11] = '{1'b1, 2'd0, 12'h007, 12'd0, 8'h00, 0, 0, 1, 1, 8'h3C};
    wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
    bp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bp_data  = '{8'h22, 8'h22, 8'h22, 8'h33, 8'h00};
    bp_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_rx    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b0;
    idle_inputs();
    bus.slave_select = '0;
    bus.address = '0;
    bus.burst_num = '0;
    bus.wr_data = '0;
    #1;
    chk("reset_outputs", {bus.rd_data, bus.rd_valid, bus.busy, bus.tx_done, bus.rx_done, bus.err}, '0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_outputs", {bus.rd_data, bus.rd_valid, bus.busy, bus.tx_done, bus.rx_done, bus.err}, '0);

    // Single-beat vectors; command is held high after completion to catch re-triggering
    for (int i = 0; i < 12; i++) begin
      txn(vt[i].rd, vt[i].sel, vt[i].addr, vt[i].burst, vt[i].d, n_err, n_tx, n_rx, n_busy, rdat);
      chk($sformatf("v%0d_err", i), n_err, vt[i].e_err);
      chk($sformatf("v%0d_tx", i), n_tx, vt[i].e_tx);
      chk($sformatf("v%0d_rx", i), n_rx, vt[i].e_rx);
      chk($sformatf("v%0d_busy", i), n_busy, vt[i].e_busy);
      chk($sformatf("v%0d_rdata", i), rdat, vt[i].e_rdat);
    end

    // Burst write crossing the top of memory, with one stall cycle
    bus.instruction = 2'b10;
    bus.slave_select = 2'd0;
    bus.address = 12'h00E;
    bus.burst_num = 12'd4;
    tick();
    chk("bw_busy", bus.busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.wr_valid = 1'b0;
        tick();
        chk("bw_stall_busy", bus.busy, 1'b1);
        chk("bw_stall_tx", bus.tx_done, 1'b0);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data = wdat[i];
      tick();
      chk($sformatf("bw_tx%0d", i), bus.tx_done, i == 3);
    end
    idle_inputs();
    tick();
    chk("bw_tx_once", bus.tx_done, 1'b0);
    tick();

    // Burst read back with rd_ready held high: no bubbles, wrap 15 -> 0
    bus.instruction = 2'b11;
    bus.address = 12'h00E;
    bus.burst_num = 12'd4;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("br_valid%0d", i), bus.rd_valid, 1'b1);
      chk($sformatf("br_data%0d", i), bus.rd_data, wdat[i]);
      chk($sformatf("br_rx%0d", i), bus.rx_done, 1'b0);
    end
    tick();
    chk("br_rx_done", bus.rx_done, 1'b1);
    chk("br_valid_end", bus.rd_valid, 1'b0);
    tick();
    chk("br_rx_once", bus.rx_done, 1'b0);
    idle_inputs();
    tick();
    tick();

    // Backpressure: read 3 beats with rd_ready 1,0,0,1,1
    bus.instruction = 2'b11;
    bus.address = 12'h00E;
    bus.burst_num = 12'd3;
    bus.rd_ready = 1'b0;
    tick();
    chk("bp_first", bus.rd_data, 8'h11);
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      bus.rd_ready = bp_ready[k];
      if (bus.rd_valid && bus.rd_ready) hs++;
      tick();
      chk($sformatf("bp_valid%0d", k), bus.rd_valid, bp_valid[k]);
      if (bp_valid[k]) chk($sformatf("bp_data%0d", k), bus.rd_data, bp_data[k]);
      chk($sformatf("bp_rx%0d", k), bus.rx_done, bp_rx[k]);
    end
    chk("bp_beats", hs, 3);
    idle_inputs();
    tick();
    tick();

    // Abort after 2 of 5 write beats
    bus.instruction = 2'b10;
    bus.address = 12'h004;
    bus.burst_num = 12'd5;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_data = 8'h61;
    tick();
    bus.wr_data = 8'h62;
    tick();
    chk("ab_busy", bus.busy, 1'b1);
    idle_inputs();
    tick();
    chk("ab_busy_off", bus.busy, 1'b0);
    chk("ab_no_tx", bus.tx_done, 1'b0);
    tick();
    chk("ab_no_tx2", bus.tx_done, 1'b0);
    txn(1'b1, 2'd0, 12'h004, 12'd1, 8'h00, n_err, n_tx, n_rx, n_busy, rdat);
    chk("ab_kept0", rdat, 8'h61);
    txn(1'b1, 2'd0, 12'h005, 12'd1, 8'h00, n_err, n_tx, n_rx, n_busy, rdat);
    chk("ab_kept1", rdat, 8'h62);

    // Asynchronous reset in the middle of a read burst
    bus.instruction = 2'b11;
    bus.address = 12'h00E;
    bus.burst_num = 12'd4;
    bus.rd_ready = 1'b0;
    tick();
    chk("rs_valid_pre", bus.rd_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rs_valid", bus.rd_valid, 1'b0);
    chk("rs_busy", bus.busy, 1'b0);
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    txn(1'b1, 2'd0, 12'h003, 12'd1, 8'h00, n_err, n_tx, n_rx, n_busy, rdat);
    chk("rs_read_data", rdat, 8'hA5);
    chk("rs_read_rx", n_rx, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
